// File: rtl/risc32_pkg.sv
// Shared definitions for the RISC32 interrupt controller: FSM states,
// config register map and the vector address helper.
package risc32_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_REQ     = 2'd1,
      ST_SERVICE = 2'd2
   } intc_state_e;

   localparam logic [1:0] INTC_ENABLE  = 2'd0;
   localparam logic [1:0] INTC_PENDING = 2'd1;
   localparam logic [1:0] INTC_ACTIVE  = 2'd2;
   localparam logic [1:0] INTC_CTRL    = 2'd3;

   localparam int GIE = 0;

   // Handler address wraps modulo 2^32.
   function automatic logic [31:0] intc_vector(input logic [31:0] base,
                                               input logic [4:0]  id);
      return base + {25'd0, id, 2'b00};
   endfunction

endpackage

// File: rtl/risc32_prio_enc.sv
// Lowest-index-first priority encoder over the interrupt candidate set.
module risc32_prio_enc #(
   parameter int NUM_IRQ = 8
) (
   input  logic [NUM_IRQ-1:0] req,
   output logic [4:0]         id,
   output logic               valid
);

   always_comb begin
      id    = 5'd0;
      valid = |req;
      // Walk downwards so the lowest set index is the last one written.
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (req[i]) begin
            id = 5'(i);
         end
      end
   end

endmodule

// File: rtl/risc32_intc.sv
// Edge-captured, fixed-priority interrupt controller with a req/ack/eoi
// handshake toward the core and a 4-register config interface.
module risc32_intc
   import risc32_pkg::*;
#(
   parameter int          NUM_IRQ     = 8,
   parameter logic [31:0] VECTOR_BASE = 32'h0000_0100
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_IRQ-1:0] irq_in,
   output logic               interrupt,
   input  logic               interrupt_ack,
   input  logic               eoi,
   output logic [4:0]         irq_id,
   output logic [31:0]        vector,
   input  logic               cfg_we,
   input  logic [1:0]         cfg_addr,
   input  logic [31:0]        cfg_wdata,
   output logic [31:0]        cfg_rdata
);

   intc_state_e        state_q, state_d;
   logic [NUM_IRQ-1:0] irq_prev_q, irq_prev_d;
   logic [NUM_IRQ-1:0] enable_q, enable_d;
   logic [NUM_IRQ-1:0] pending_q, pending_d;
   logic [NUM_IRQ-1:0] active_q, active_d;
   logic               gie_q, gie_d;
   logic               interrupt_q, interrupt_d;
   logic [4:0]         irq_id_q, irq_id_d;
   logic [31:0]        vector_q, vector_d;

   logic [NUM_IRQ-1:0] rise;
   logic [NUM_IRQ-1:0] cand;
   logic [NUM_IRQ-1:0] id_mask;
   logic [NUM_IRQ-1:0] wr_mask;
   logic [4:0]         win_id;
   logic               win_vld;
   logic               ack_take;
   logic               req_stale;

   risc32_prio_enc #(
      .NUM_IRQ (NUM_IRQ)
   ) u_prio_enc (
      .req   (cand),
      .id    (win_id),
      .valid (win_vld)
   );

   always_comb begin
      rise       = irq_in & ~irq_prev_q;
      irq_prev_d = irq_in;
      cand       = pending_q & enable_q;
      id_mask    = NUM_IRQ'(1) << irq_id_q;
      wr_mask    = cfg_wdata[NUM_IRQ-1:0];
      ack_take   = (state_q == ST_REQ) && interrupt_ack;
      req_stale  = ((pending_q & id_mask) == '0) ||
                   ((enable_q & id_mask) == '0) || !gie_q;
   end

   always_comb begin
      enable_d = enable_q;
      gie_d    = gie_q;
      if (cfg_we && (cfg_addr == INTC_ENABLE)) begin
         enable_d = wr_mask;
      end
      if (cfg_we && (cfg_addr == INTC_CTRL)) begin
         gie_d = cfg_wdata[GIE];
      end
   end

   // A fresh edge is OR-ed in last so it beats both W1C and the ack clear.
   always_comb begin
      pending_d = pending_q;
      if (cfg_we && (cfg_addr == INTC_PENDING)) begin
         pending_d = pending_d & ~wr_mask;
      end
      if (ack_take) begin
         pending_d = pending_d & ~id_mask;
      end
      pending_d = pending_d | rise;
   end

   always_comb begin
      state_d     = state_q;
      active_d    = active_q;
      interrupt_d = interrupt_q;
      irq_id_d    = irq_id_q;
      vector_d    = vector_q;
      case (state_q)
         ST_IDLE: begin
            if (gie_q && win_vld) begin
               irq_id_d    = win_id;
               vector_d    = intc_vector(VECTOR_BASE, win_id);
               interrupt_d = 1'b1;
               state_d     = ST_REQ;
            end
         end
         ST_REQ: begin
            if (interrupt_ack) begin
               active_d    = id_mask;
               interrupt_d = 1'b0;
               state_d     = ST_SERVICE;
            end else if (req_stale) begin
               interrupt_d = 1'b0;
               state_d     = ST_IDLE;
            end
         end
         ST_SERVICE: begin
            if (eoi) begin
               active_d = '0;
               state_d  = ST_IDLE;
            end
         end
         default: begin
            state_d     = ST_IDLE;
            interrupt_d = 1'b0;
            active_d    = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         irq_prev_q  <= '0;
         enable_q    <= '0;
         pending_q   <= '0;
         active_q    <= '0;
         gie_q       <= 1'b0;
         interrupt_q <= 1'b0;
         irq_id_q    <= 5'd0;
         vector_q    <= 32'h0;
      end else begin
         state_q     <= state_d;
         irq_prev_q  <= irq_prev_d;
         enable_q    <= enable_d;
         pending_q   <= pending_d;
         active_q    <= active_d;
         gie_q       <= gie_d;
         interrupt_q <= interrupt_d;
         irq_id_q    <= irq_id_d;
         vector_q    <= vector_d;
      end
   end

   always_comb begin
      cfg_rdata = 32'h0;
      case (cfg_addr)
         INTC_ENABLE:  cfg_rdata = 32'(enable_q);
         INTC_PENDING: cfg_rdata = 32'(pending_q);
         INTC_ACTIVE:  cfg_rdata = 32'(active_q);
         INTC_CTRL:    cfg_rdata = {31'd0, gie_q};
         default:      cfg_rdata = 32'h0;
      endcase
   end

   assign interrupt = interrupt_q;
   assign irq_id    = irq_id_q;
   assign vector    = vector_q;

endmodule

// File: doc/risc32_intc.md
# risc32_intc

Interrupt controller for the RISC32 core. It collects up to NUM_IRQ edge-triggered peripheral interrupt sources and arbitrates them by fixed priority onto the core's single `interrupt` input. It completes a request/acknowledge handshake with the core's `interrupt_ack` output, then holds the granted source in service until the core signals end-of-interrupt. Software configures and observes it through a small 4-register word-wide interface.

## Interface
- NUM_IRQ, 8, number of interrupt sources (1..32); index 0 is highest priority.
- VECTOR_BASE, 32'h0000_0100, handler table base; vector = VECTOR_BASE + (id << 2).
- Ports:
  - clk  in  1  system clock, rising edge.
  - reset  in  1  asynchronous, active-low reset (0 = reset asserted).
  - irq_in  in  NUM_IRQ  peripheral request lines, synchronous to clk, rising-edge sensitive.
  - interrupt  out  1  request to core, registered.
  - interrupt_ack  in  1  core acknowledge, 1-cycle pulse.
  - eoi  in  1  end-of-interrupt pulse from core.
  - irq_id  out  5  id of the requested/in-service source, registered.
  - vector  out  32  handler address for irq_id, registered.
  - cfg_we  in  1  config write strobe.
  - cfg_addr  in  2  register select.
  - cfg_wdata  in  32  write data.
  - cfg_rdata  out  32  read data, combinational from cfg_addr.

## Operation
- Registers, bits above NUM_IRQ-1 read 0:
  - 0 ENABLE (R/W mask).
  - 1 PENDING (read; write-1-to-clear).
  - 2 ACTIVE (read-only, one-hot or 0).
  - 3 CTRL (bit0 GIE global enable, R/W; other bits read 0).
- Edge capture runs in every state. `irq_prev <= irq_in`. For each i, irq_in[i] & ~irq_prev[i] sets PENDING[i].
- Candidate set = PENDING & ENABLE. The winner is the lowest set index.
- FSM states: IDLE, REQ, SERVICE.
  - IDLE: if GIE=1 and candidate set is nonzero, latch winner into irq_id, load vector, set interrupt=1, go to REQ.
  - REQ: interrupt held at 1, and irq_id/vector stay frozen. The priority winner is not re-evaluated.
    - On interrupt_ack: clear PENDING[irq_id], set ACTIVE[irq_id], interrupt=0, go to SERVICE.
    - Otherwise, if PENDING[irq_id]=0, ENABLE[irq_id]=0, or GIE=0: withdraw (interrupt=0) and go to IDLE.
    - Ack takes precedence over withdraw in the same cycle.
  - SERVICE: no nesting; new candidates stay pending. On eoi: ACTIVE=0, go to IDLE.
- interrupt_ack in IDLE/SERVICE is ignored. eoi in IDLE/REQ is ignored.
- Same-cycle conflicts on a PENDING bit: a new edge wins over both W1C and ack clear, so the bit stays 1.
- vector arithmetic is 32-bit, modulo 2^32.
- irq_id and vector keep their last value in IDLE.
- Reset mid-operation: everything returns to reset state immediately, and any in-flight request or service is discarded.

## Timing
- Reset values:
  - interrupt=0, irq_id=0, vector=32'h0.
  - FSM=IDLE; ENABLE, PENDING, ACTIVE, GIE and irq_prev all 0.
  - cfg_rdata reflects the reset registers.
- Capture latency: irq_in rises before edge k → PENDING set at edge k.
- Request latency: if enabled and IDLE, interrupt, irq_id and vector are valid after edge k+1.
- Ack latency: ack high at edge m → interrupt low and ACTIVE set after edge m. The next request can be raised no earlier than 1 cycle after the eoi edge.
- Config writes take effect at the write edge. A write setting ENABLE/GIE makes an already-pending source request at the following edge.
- cfg_rdata updates combinationally with cfg_addr and reflects register state after the last edge.

## Structure
- Shared package `risc32_pkg`:
  - FSM state encodings.
  - Register address constants (INTC_ENABLE, INTC_PENDING, INTC_ACTIVE, INTC_CTRL).
  - CTRL bit index GIE.
- Sub-module `risc32_prio_enc`: combinational NUM_IRQ-input lowest-index-first priority encoder with outputs id[4:0] and valid.
- Remaining logic (edge capture, registers, FSM) lives in the top module.

## Test plan
- Reset, then set ENABLE=0xFF and GIE=1, then pulse irq_in[3] → interrupt=1 two edges after the rise, irq_id=3, vector=0x10C.
- Raise irq_in[5] and irq_in[2] in the same cycle → irq_id=2. Ack, then eoi → irq_id=5, vector=0x114 next.
- In REQ for id 4, W1C PENDING with 0x10 → interrupt drops next edge, FSM returns to IDLE, ACTIVE=0.
- In SERVICE for id 1, raise irq_in[0] → interrupt stays 0 and PENDING[0]=1. After eoi, request id 0.
- Same cycle: ack for id 6 plus a new rising edge on irq_in[6] → ACTIVE=0x40 and PENDING[6]=1.
- Assert reset (0) during SERVICE → all registers read 0 and interrupt=0. Afterwards, source edges still capture but do not request while ENABLE=0.
